// File: rtl/router_pkg.sv
// Shared definitions for the router receive port: FSM encoding, header field positions,
// per-packet status record and the buffer entry packing helper.
package router_pkg;

   localparam int LEN_MSB  = 7;
   localparam int LEN_LSB  = 2;
   localparam int ADDR_MSB = 1;
   localparam int ADDR_LSB = 0;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_HDR_WAIT = 2'd1;
   localparam logic [1:0] ST_BODY     = 2'd2;
   localparam logic [1:0] ST_DONE     = 2'd3;

   typedef enum logic [1:0] {
      RX_IDLE     = ST_IDLE,
      RX_HDR_WAIT = ST_HDR_WAIT,
      RX_BODY     = ST_BODY,
      RX_DONE     = ST_DONE
   } rx_state_e;

   typedef struct packed {
      logic parity_err;
      logic addr_err;
      logic trunc_err;
   } rx_status_t;

   // Buffer entry layout is {sop, eop, data}.
   function automatic logic [9:0] buf_entry(input logic sop, input logic eop, input logic [7:0] data);
      return {sop, eop, data};
   endfunction

endpackage

// File: rtl/router_rx_port_if.sv
// Router FIFO drain, output byte stream and status strobe of one receive port.
interface router_rx_port_if;
   logic       vld_out;
   logic [7:0] fifo_data;
   logic       read_enb;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready;
   logic       m_sop;
   logic       m_eop;
   logic       pkt_done;
   logic       parity_err;
   logic       addr_err;
   logic       trunc_err;

   modport master (
      input  vld_out, fifo_data, m_ready,
      output read_enb, m_data, m_valid, m_sop, m_eop, pkt_done, parity_err, addr_err, trunc_err
   );

   modport slave (
      output vld_out, fifo_data, m_ready,
      input  read_enb, m_data, m_valid, m_sop, m_eop, pkt_done, parity_err, addr_err, trunc_err
   );
endinterface

// File: rtl/router_rx_buf.sv
// Synchronous FIFO of {sop, eop, data} entries with occupancy count; the newest entry's
// eop bit can be forced when a packet is cut short.
module router_rx_buf #(
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned CW    = AW + 1
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic          fix_eop_i,
   input  logic [9:0]    wdata_i,
   output logic [9:0]    rdata_o,
   output logic [CW-1:0] count_o,
   output logic          empty_o
);
   logic [9:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;

   // Pointer and occupancy tracking.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Entry storage; the eop fix-up targets the most recently written entry.
   always_ff @(posedge clock) begin
      if (push_i) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end else if (fix_eop_i && (count_q != '0)) begin
         mem_q[wr_ptr_q - AW'(1)][8] <= 1'b1;
      end
   end

   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = empty_o ? 10'd0 : mem_q[rd_ptr_q];

   router_rx_buf_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
      .clock   (clock),
      .reset   (reset),
      .push_i  (push_i),
      .pop_i   (pop_i),
      .count_i (count_q)
   );
endmodule

// File: rtl/router_rx_buf_chk.sv
// Occupancy assertions for the receive output buffer.
module router_rx_buf_chk #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CW    = 3
) (
   input logic          clock,
   input logic          reset,
   input logic          push_i,
   input logic          pop_i,
   input logic [CW-1:0] count_i
);
   a_no_overflow: assert property (@(posedge clock) disable iff (reset)
      !(push_i && !pop_i && (32'(count_i) == DEPTH)));

   a_no_underflow: assert property (@(posedge clock) disable iff (reset)
      !(pop_i && (count_i == '0)));
endmodule

// File: rtl/router_rx_port.sv
// Receive side of one router output port: drains the port FIFO, re-frames packets onto a
// valid/ready byte stream and reports per-packet status. ROUTER_RX_STATS_EN adds counters.
module router_rx_port
   import router_pkg::*;
#(
   parameter logic [1:0]  PORT_ADDR = 2'd0,
   parameter int unsigned BUF_DEPTH = 4,
   parameter int unsigned ABORT_CYC = 64
) (
   input  logic             clock,
   input  logic             reset,
   router_rx_port_if.master bus
`ifdef ROUTER_RX_STATS_EN
   ,
   output logic [15:0]      pkt_cnt,
   output logic [15:0]      err_cnt
`endif
);
   localparam int unsigned CW  = $clog2(BUF_DEPTH) + 1;
   localparam int unsigned ACW = $clog2(ABORT_CYC);

   logic [1:0]     state_q, state_d;
   logic           inflight_q;
   logic [6:0]     rd_left_q, rd_left_d;
   logic [7:0]     par_q, par_d;
   rx_status_t     status_q, status_d;
   logic [ACW-1:0] abort_q, abort_d;
   logic           need_byte_s, read_s, push_s, pop_s, fix_eop_s, empty_s, done_s;
   logic [9:0]     wdata_s, head_s;
   logic [CW-1:0]  count_s;
   logic [5:0]     len_s;

   assign len_s  = bus.fifo_data[LEN_MSB:LEN_LSB];
   assign read_s = !reset && bus.vld_out && need_byte_s &&
                   ((32'(count_s) + 32'(inflight_q)) < BUF_DEPTH);
   assign pop_s  = !empty_s && bus.m_ready;
   assign done_s = (state_q == ST_DONE);

   // Packet framing FSM; rd_left counts bytes still to capture, reads stop once the
   // outstanding read already covers the last one.
   always_comb begin
      state_d     = state_q;
      rd_left_d   = rd_left_q;
      par_d       = par_q;
      status_d    = status_q;
      abort_d     = '0;
      need_byte_s = 1'b0;
      push_s      = 1'b0;
      fix_eop_s   = 1'b0;
      wdata_s     = 10'd0;
      case (state_q)
         ST_IDLE: begin
            need_byte_s = 1'b1;
            if (read_s) state_d = ST_HDR_WAIT;
            else        state_d = ST_IDLE;
         end
         ST_HDR_WAIT: begin
            if (inflight_q) begin
               push_s    = 1'b1;
               wdata_s   = buf_entry(1'b1, len_s == 6'd0, bus.fifo_data);
               rd_left_d = {1'b0, len_s} + 7'd1;
               par_d     = bus.fifo_data;
               status_d  = '{parity_err: 1'b0,
                              addr_err:   (bus.fifo_data[ADDR_MSB:ADDR_LSB] != PORT_ADDR),
                              trunc_err:  1'b0};
               state_d   = ST_BODY;
            end else begin
               state_d   = ST_HDR_WAIT;
            end
         end
         ST_BODY: begin
            need_byte_s = (rd_left_q > {6'd0, inflight_q});
            if (inflight_q) begin
               rd_left_d = rd_left_q - 7'd1;
               if (rd_left_q > 7'd1) begin
                  push_s  = 1'b1;
                  wdata_s = buf_entry(1'b0, rd_left_q == 7'd2, bus.fifo_data);
                  par_d   = par_q ^ bus.fifo_data;
               end else begin
                  status_d.parity_err = (par_q != bus.fifo_data);
                  state_d             = ST_DONE;
               end
            end else if ((rd_left_q != 7'd0) && !bus.vld_out) begin
               if (abort_q == ACW'(ABORT_CYC - 1)) begin
                  fix_eop_s           = 1'b1;
                  status_d.parity_err = 1'b0;
                  status_d.trunc_err  = 1'b1;
                  state_d             = ST_DONE;
               end else begin
                  abort_d = abort_q + ACW'(1);
               end
            end else begin
               abort_d = '0;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         inflight_q <= 1'b0;
         rd_left_q  <= 7'd0;
         par_q      <= 8'd0;
         status_q   <= '0;
         abort_q    <= '0;
      end else begin
         state_q    <= state_d;
         inflight_q <= read_s;
         rd_left_q  <= rd_left_d;
         par_q      <= par_d;
         status_q   <= status_d;
         abort_q    <= abort_d;
      end
   end

   router_rx_buf #(.DEPTH(BUF_DEPTH)) u_buf (
      .clock     (clock),
      .reset     (reset),
      .push_i    (push_s),
      .pop_i     (pop_s),
      .fix_eop_i (fix_eop_s),
      .wdata_i   (wdata_s),
      .rdata_o   (head_s),
      .count_o   (count_s),
      .empty_o   (empty_s)
   );

   assign bus.read_enb   = read_s;
   assign bus.m_valid    = !empty_s;
   assign bus.m_sop      = head_s[9];
   assign bus.m_eop      = head_s[8];
   assign bus.m_data     = head_s[7:0];
   assign bus.pkt_done   = done_s;
   assign bus.parity_err = done_s && status_q.parity_err;
   assign bus.addr_err   = done_s && status_q.addr_err;
   assign bus.trunc_err  = done_s && status_q.trunc_err;

`ifdef ROUTER_RX_STATS_EN
   logic [15:0] pkt_cnt_q, err_cnt_q;

   // Saturating packet and errored-packet counters.
   always_ff @(posedge clock) begin
      if (reset) begin
         pkt_cnt_q <= 16'd0;
         err_cnt_q <= 16'd0;
      end else if (done_s) begin
         if (pkt_cnt_q != 16'hFFFF) pkt_cnt_q <= pkt_cnt_q + 16'd1;
         if ((|status_q) && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;
      end
   end

   assign pkt_cnt = pkt_cnt_q;
   assign err_cnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_router_rx_port.sv
// Self-checking bench for router_rx_port: queue-based upstream FIFO, expected stream and
// status queues built from the packet rules, table vectors plus random packets.
module tb_router_rx_port;
   import router_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b1;
   router_rx_port_if bus ();
`ifdef ROUTER_RX_STATS_EN
   logic [15:0] pkt_cnt, err_cnt;
`endif

   router_rx_port #(.PORT_ADDR(2'd0), .BUF_DEPTH(4), .ABORT_CYC(64)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.master)
`ifdef ROUTER_RX_STATS_EN
      ,
      .pkt_cnt (pkt_cnt),
      .err_cnt (err_cnt)
`endif
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [7:0] hdr;
      logic [7:0] seed;
      logic       ovr;
      logic [7:0] par_val;
      int         mode;
      logic       exp_par;
      logic       exp_addr;
   } vec_t;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] fifo_q[$];
   logic [9:0] exp_stream[$];
   logic [2:0] exp_stat[$];
   int         ready_mode = 0;
   int         rd_cnt = 0;
   int         model_pkts = 0;
   int         model_errs = 0;
   logic       prev_stall = 1'b0;
   logic [9:0] prev_head = 10'd0;

   function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endfunction

   function automatic void unexpected(input string name, input logic [31:0] got);
      checks++;
      errors++;
      $display("FAIL %s unexpected value=%0h", name, got);
   endfunction

   // Expected status from the packet rules: all bytes incl. parity XOR to zero when intact.
   function automatic logic [2:0] model_status(input logic [7:0] hdr, input logic [7:0] pay[$],
                                               input logic [7:0] par_byte);
      logic [7:0] x;
      x = hdr ^ par_byte;
      foreach (pay[i]) x ^= pay[i];
      return {x != 8'd0, hdr[1:0] != 2'd0, 1'b0};
   endfunction

   // One clock: sample at the falling edge, then drive upstream/sink #1 after the rising edge.
   task automatic tick();
      logic       rd;
      logic [9:0] head;
      rd   = bus.read_enb;
      head = {bus.m_sop, bus.m_eop, bus.m_data};
      if (rd) rd_cnt++;
      if (prev_stall && !reset) begin
         check("hold_valid", bus.m_valid, 1);
         check("hold_head", head, prev_head);
      end
      if (!reset && bus.m_valid && bus.m_ready) begin
         if (exp_stream.size() == 0) unexpected("stream_extra", head);
         else check("stream", head, exp_stream.pop_front());
      end
      prev_stall = !reset && bus.m_valid && !bus.m_ready;
      prev_head  = head;
      if (bus.pkt_done === 1'b1) begin
         if (exp_stat.size() == 0) unexpected("status_extra", {bus.parity_err, bus.addr_err, bus.trunc_err});
         else check("status", {bus.parity_err, bus.addr_err, bus.trunc_err}, exp_stat.pop_front());
      end
      @(posedge clock);
      #1;
      if (rd && fifo_q.size() != 0) bus.fifo_data = fifo_q.pop_front();
      bus.vld_out = (fifo_q.size() != 0);
      case (ready_mode)
         0:       bus.m_ready = 1'b1;
         1:       bus.m_ready = 1'($urandom_range(0, 1));
         default: bus.m_ready = 1'b0;
      endcase
      @(negedge clock);
   endtask

   task automatic send(input logic [7:0] hdr, input logic [7:0] pay[$], input logic [7:0] par_byte,
                       input logic [2:0] exp_st);
      int len;
      len = int'(hdr[7:2]);
      fifo_q.push_back(hdr);
      exp_stream.push_back({1'b1, len == 0, hdr});
      foreach (pay[i]) begin
         fifo_q.push_back(pay[i]);
         exp_stream.push_back({1'b0, i == len - 1, pay[i]});
      end
      fifo_q.push_back(par_byte);
      exp_stat.push_back(exp_st);
      model_pkts++;
      if (exp_st != 3'd0) model_errs++;
      bus.vld_out = 1'b1;
      #1;
   endtask

   task automatic drain(input int max_cyc);
      int n;
      n = 0;
      while ((exp_stream.size() != 0 || exp_stat.size() != 0 || fifo_q.size() != 0) && n < max_cyc) begin
         tick();
         n++;
      end
      checks++;
      if (n >= max_cyc) begin
         errors++;
         $display("FAIL drain_timeout stream_left=%0d status_left=%0d fifo_left=%0d",
                  exp_stream.size(), exp_stat.size(), fifo_q.size());
         exp_stream.delete();
         exp_stat.delete();
         fifo_q.delete();
         bus.vld_out = 1'b0;
      end
      repeat (4) tick();
   endtask

   task automatic reset_and_check();
      ready_mode  = 2;
      bus.m_ready = 1'b0;
      reset       = 1'b1;
      prev_stall  = 1'b0;
      fifo_q.delete();
      exp_stream.delete();
      exp_stat.delete();
      fifo_q.push_back(8'hA5);
      bus.vld_out = 1'b1;
      #1;
      check("rst_read_enb_early", bus.read_enb, 0);
      tick();
      tick();
      check("rst_read_enb", bus.read_enb, 0);
      check("rst_m_valid", bus.m_valid, 0);
      check("rst_m_head", {bus.m_sop, bus.m_eop, bus.m_data}, 0);
      check("rst_pkt_done", bus.pkt_done, 0);
      check("rst_flags", {bus.parity_err, bus.addr_err, bus.trunc_err}, 0);
`ifdef ROUTER_RX_STATS_EN
      check("rst_pkt_cnt", pkt_cnt, 0);
      check("rst_err_cnt", err_cnt, 0);
`endif
      fifo_q.delete();
      bus.vld_out = 1'b0;
      reset       = 1'b0;
      model_pkts  = 0;
      model_errs  = 0;
      #1;
   endtask

   initial begin
      vec_t       vecs[8];
      logic [7:0] pay[$];
      logic [7:0] par;

      bus.vld_out   = 1'b0;
      bus.fifo_data = 8'd0;
      bus.m_ready   = 1'b0;

      vecs[0] = '{8'h0C, 8'h11, 1'b0, 8'h00, 0, 1'b0, 1'b0};
      vecs[1] = '{8'h0C, 8'h11, 1'b1, 8'h00, 0, 1'b1, 1'b0};
      vecs[2] = '{8'h0E, 8'h11, 1'b0, 8'h00, 0, 1'b0, 1'b1};
      vecs[3] = '{8'h0D, 8'h40, 1'b1, 8'hFF, 1, 1'b1, 1'b1};
      vecs[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 0, 1'b0, 1'b0};
      vecs[5] = '{8'h01, 8'h00, 1'b1, 8'h01, 1, 1'b0, 1'b1};
      vecs[6] = '{8'h50, 8'h01, 1'b0, 8'h00, 1, 1'b0, 1'b0};
      vecs[7] = '{8'hFC, 8'h03, 1'b1, 8'h77, 1, 1'b1, 1'b0};

      reset_and_check();

      // Table vectors.
      foreach (vecs[v]) begin
         ready_mode = vecs[v].mode;
         pay.delete();
         par = vecs[v].hdr;
         for (int i = 0; i < int'(vecs[v].hdr[7:2]); i++) begin
            pay.push_back(8'(int'(vecs[v].seed) + i * 17));
            par ^= pay[i];
         end
         if (vecs[v].ovr) par = vecs[v].par_val;
         send(vecs[v].hdr, pay, par, {vecs[v].exp_par, vecs[v].exp_addr, 1'b0});
         drain(1000);
      end

      // Sink stalled during a 20-byte payload: reads stop at four buffered/in-flight bytes.
      ready_mode  = 2;
      bus.m_ready = 1'b0;
      rd_cnt      = 0;
      pay.delete();
      par = 8'h50;
      for (int i = 0; i < 20; i++) begin
         pay.push_back(8'(8'hA0 + i));
         par ^= pay[i];
      end
      send(8'h50, pay, par, 3'b000);
      repeat (30) tick();
      check("stall_reads", rd_cnt, 4);
      check("stall_valid", bus.m_valid, 1);
      check("stall_head", {bus.m_sop, bus.m_eop, bus.m_data}, {2'b10, 8'h50});
      ready_mode = 0;
      drain(500);

      // Truncation: len 5 header, upstream dries up after two payload bytes.
      ready_mode  = 2;
      bus.m_ready = 1'b0;
      fifo_q.push_back(8'h14);
      fifo_q.push_back(8'h61);
      fifo_q.push_back(8'h62);
      exp_stream.push_back({2'b10, 8'h14});
      exp_stream.push_back({2'b00, 8'h61});
      exp_stream.push_back({2'b01, 8'h62});
      exp_stat.push_back(3'b001);
      model_pkts++;
      model_errs++;
      bus.vld_out = 1'b1;
      #1;
      repeat (60) tick();
      check("trunc_not_early", exp_stat.size(), 1);
      repeat (20) tick();
      check("trunc_reported", exp_stat.size(), 0);
      ready_mode = 0;
      drain(200);
      pay.delete();
      pay.push_back(8'h11);
      pay.push_back(8'h22);
      pay.push_back(8'h33);
      send(8'h0C, pay, 8'h0C ^ 8'h11 ^ 8'h22 ^ 8'h33, 3'b000);
      drain(200);

      // Random packets, several queued back to back, random sink stalls.
      ready_mode = 1;
      for (int r = 0; r < 8; r++) begin
         for (int k = 0; k < 3; k++) begin
            logic [7:0] hdr;
            hdr = {6'($urandom_range(0, 12)), ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0};
            pay.delete();
            par = hdr;
            for (int i = 0; i < int'(hdr[7:2]); i++) begin
               pay.push_back(8'($urandom));
               par ^= pay[i];
            end
            if ($urandom_range(0, 3) == 0) par = par ^ 8'(8'h01 << $urandom_range(0, 7));
            send(hdr, pay, par, model_status(hdr, pay, par));
         end
         drain(2000);
      end

      // Reset in the middle of a packet: nothing from it may surface afterwards.
      ready_mode = 2;
      pay.delete();
      for (int i = 0; i < 10; i++) pay.push_back(8'(i + 1));
      send(8'h28, pay, 8'h00, 3'b000);
      repeat (6) tick();
      reset_and_check();
      ready_mode = 0;
      repeat (10) tick();

      // Back-to-back len 0 and len 63.
      pay.delete();
      send(8'h00, pay, 8'h00, 3'b000);
      par = 8'hFC;
      for (int i = 0; i < 63; i++) begin
         pay.push_back(8'(i * 3 + 5));
         par ^= pay[i];
      end
      send(8'hFC, pay, par, 3'b000);
      drain(500);
`ifdef ROUTER_RX_STATS_EN
      check("pkt_cnt", pkt_cnt, model_pkts);
      check("err_cnt", err_cnt, model_errs);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
